// File: rtl/wb_sram_line_en_master_bridge_if.sv
// Wishbone classic bus bundle used by the SRAM line bridge.
// The master modport drives the request side; the slave modport answers it.
interface wb_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  adr;
  logic [DATA_WIDTH-1:0]     dat_w;
  logic [DATA_WIDTH-1:0]     dat_r;
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      ack;
  logic                      err;

  modport master (
    output adr, dat_w, cyc, stb, we, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_line_en_master_bridge.sv
// SRAM-style strobe interface to a single-beat Wishbone master.
// One request at a time: IDLE captures a strobe, ACTIVE holds the bus
// until ACK/ERR, DONE pulses done for one cycle.
// Optional watchdog: define WB_SRAM_MASTER_TIMEOUT_EN to abort a bus cycle
// that sees no ACK/ERR within TIMEOUT_CYCLES cycles (reported as err).
module wb_sram_line_en_master_bridge #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic [ADDRESS_WIDTH-$clog2(DATA_WIDTH/8)-1:0]     sram_addr,
  input  logic                                              sram_read_en,
  input  logic                                              sram_write_en,
  input  logic [DATA_WIDTH-1:0]                             sram_write_data,
  output logic [DATA_WIDTH-1:0]                             sram_read_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err,
  wb_if.master                                              wb_m
);

  localparam int OFFS = $clog2(DATA_WIDTH/8);
  localparam int WAW  = ADDRESS_WIDTH - OFFS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WAW-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif

  // Next-state logic: capture in IDLE, wait for slave response in ACTIVE,
  // single-cycle completion in DONE. ERR outranks ACK.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
    cnt_d   = 8'd0;
`endif
    unique case (state_q)
      IDLE: begin
        if (sram_read_en || sram_write_en) begin
          addr_d  = sram_addr;
          data_d  = sram_write_data;
          we_d    = sram_write_en;
          cyc_d   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (wb_m.err) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (wb_m.ack) begin
          err_d   = 1'b0;
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = wb_m.dat_r;
          end
        end
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Bus and status outputs come straight from registers.
  always_comb begin
    wb_m.cyc       = cyc_q;
    wb_m.stb       = cyc_q;
    wb_m.we        = we_q;
    wb_m.adr       = {addr_q, {OFFS{1'b0}}};
    wb_m.dat_w     = data_q;
    wb_m.sel       = '1;
    sram_read_data = rdata_q;
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    err            = err_q;
  end

endmodule

// File: tb/tb_wb_sram_line_en_master_bridge.sv
// Self-checking bench for wb_sram_line_en_master_bridge.
// Table of single transactions with a completion scoreboard, followed by
// hand-written sequences for busy drops, back-to-back, timeout/hold, reset.
module tb_wb_sram_line_en_master_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  sram_addr = '0;
  logic        sram_read_en = 1'b0;
  logic        sram_write_en = 1'b0;
  logic [31:0] sram_write_data = '0;
  logic [31:0] sram_read_data;
  logic        busy;
  logic        done;
  logic        err;

  int assertCount = 0;
  int failCount = 0;

  wb_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) wb ();

  wb_sram_line_en_master_bridge #(
    .ADDRESS_WIDTH(10),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .sram_addr(sram_addr),
    .sram_read_en(sram_read_en),
    .sram_write_en(sram_write_en),
    .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data),
    .busy(busy),
    .done(done),
    .err(err),
    .wb_m(wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ackDelay;
    logic        sAck;
    logic        sErr;
    logic [31:0] sRdata;
    logic [9:0]  expAdr;
    logic        expWe;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        errv;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for done, pops the scoreboard and checks completion.
  task automatic checkOutput();
    int n;
    exp_t e;
    n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
    expectEq("done_seen", done, 1);
    if (expQ.size() == 0) begin
      expectEq("scoreboard_nonempty", 0, 1);
    end else begin
      e = expQ.pop_front();
      expectEq("done_err", err, e.errv);
      expectEq("done_rdata", sram_read_data, e.rdata);
    end
    expectEq("done_cyc_low", wb.cyc, 0);
    expectEq("done_busy", busy, 1);
    tick();
    expectEq("done_one_pulse", done, 0);
    expectEq("idle_busy", busy, 0);
  endtask

  // Drives one request, plays the slave side and checks the bus beat.
  task automatic applyStimulus(input vec_t v);
    int n;
    expQ.push_back('{rdata: v.expRdata, errv: v.expErr});
    sram_addr = v.addr;
    sram_read_en = v.rd;
    sram_write_en = v.wr;
    sram_write_data = v.wdata;
    tick();
    sram_read_en = 1'b0;
    sram_write_en = 1'b0;
    n = 0;
    while (!wb.cyc && n < 8) begin
      tick();
      n++;
    end
    expectEq("cyc_rise", wb.cyc, 1);
    expectEq("stb", wb.stb, 1);
    expectEq("adr", wb.adr, v.expAdr);
    expectEq("we", wb.we, v.expWe);
    expectEq("sel", wb.sel, 4'hF);
    expectEq("busy_active", busy, 1);
    if (v.expWe) expectEq("dat_w", wb.dat_w, v.wdata);
    for (int i = 0; i < v.ackDelay; i++) begin
      tick();
      expectEq("cyc_hold", wb.cyc, 1);
      expectEq("adr_hold", wb.adr, v.expAdr);
    end
    wb.ack = v.sAck;
    wb.err = v.sErr;
    wb.dat_r = v.sRdata;
    tick();
    wb.ack = 1'b0;
    wb.err = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int holdBad;
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.dat_r = '0;

    vecs[0] = '{1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 2, 1'b1, 1'b0, 32'h0,        10'h014, 1'b1, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h0A, 32'h0,        0, 1'b1, 1'b0, 32'h12345678, 10'h028, 1'b0, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h0A, 32'h0,        0, 1'b1, 1'b1, 32'hAAAA5555, 10'h028, 1'b0, 32'h12345678, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h3F, 32'hCAFEF00D, 1, 1'b1, 1'b0, 32'h11112222, 10'h0FC, 1'b1, 32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 32'h0,        3, 1'b0, 1'b1, 32'h0F0F0F0F, 10'h3FC, 1'b0, 32'h12345678, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 32'h0,        0, 1'b1, 1'b0, 32'hA5A5A5A5, 10'h000, 1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 0, 1'b1, 1'b0, 32'h5A5A5A5A, 10'h3FC, 1'b1, 32'hA5A5A5A5, 1'b0};

    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    expectEq("rst_cyc", wb.cyc, 0);
    expectEq("rst_stb", wb.stb, 0);
    expectEq("rst_we", wb.we, 0);
    expectEq("rst_busy", busy, 0);
    expectEq("rst_done", done, 0);
    expectEq("rst_err", err, 0);
    expectEq("rst_rdata", sram_read_data, 0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    expectEq("scoreboard_drained", expQ.size(), 0);

    // Strobes while busy are dropped; no second bus cycle follows.
    sram_addr = 8'h10;
    sram_read_en = 1'b1;
    tick();
    sram_read_en = 1'b0;
    expectEq("drop_cyc", wb.cyc, 1);
    sram_addr = 8'h55;
    sram_write_en = 1'b1;
    sram_write_data = 32'h99999999;
    tick();
    expectEq("drop_adr_stable", wb.adr, 10'h040);
    expectEq("drop_we_stable", wb.we, 0);
    wb.ack = 1'b1;
    wb.dat_r = 32'h01020304;
    tick();
    wb.ack = 1'b0;
    expectEq("drop_done", done, 1);
    expectEq("drop_rdata", sram_read_data, 32'h01020304);
    tick();
    sram_write_en = 1'b0;
    expectEq("drop_idle_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectEq("drop_no_second_cyc", wb.cyc, 0);
    end

    // Minimum latency and acceptance on the cycle right after done.
    sram_addr = 8'h11;
    sram_read_en = 1'b1;
    tick();
    sram_read_en = 1'b0;
    expectEq("lat_cyc_c1", wb.cyc, 1);
    wb.ack = 1'b1;
    wb.dat_r = 32'h0BADF00D;
    tick();
    wb.ack = 1'b0;
    expectEq("lat_done_c2", done, 1);
    expectEq("lat_rdata", sram_read_data, 32'h0BADF00D);
    tick();
    expectEq("lat_idle_c3", busy, 0);
    sram_addr = 8'h12;
    sram_read_en = 1'b1;
    tick();
    sram_read_en = 1'b0;
    expectEq("b2b_cyc", wb.cyc, 1);
    expectEq("b2b_adr", wb.adr, 10'h048);
    wb.ack = 1'b1;
    wb.dat_r = 32'h600DCAFE;
    tick();
    wb.ack = 1'b0;
    expectEq("b2b_rdata", sram_read_data, 32'h600DCAFE);
    tick();

    // Silent slave: watchdog abort when enabled, otherwise the cycle is held.
    sram_addr = 8'h20;
    sram_read_en = 1'b1;
    wb.dat_r = 32'h77777777;
    tick();
    sram_read_en = 1'b0;
`ifdef WB_SRAM_MASTER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      expectEq("to_cyc_held", wb.cyc, 1);
      tick();
    end
    expectEq("to_cyc_last", wb.cyc, 1);
    tick();
    expectEq("to_cyc_drop", wb.cyc, 0);
    expectEq("to_done", done, 1);
    expectEq("to_err", err, 1);
    expectEq("to_rdata_kept", sram_read_data, 32'h600DCAFE);
    tick();
`else
    holdBad = 0;
    for (int i = 0; i < 110; i++) begin
      if (wb.cyc !== 1'b1 || done !== 1'b0) holdBad++;
      tick();
    end
    expectEq("hold_cyc_110", holdBad, 0);
    wb.err = 1'b1;
    tick();
    wb.err = 1'b0;
    expectEq("hold_err_done", done, 1);
    expectEq("hold_err", err, 1);
    expectEq("hold_rdata_kept", sram_read_data, 32'h600DCAFE);
    tick();
`endif

    // Reset two cycles into ACTIVE.
    sram_addr = 8'h30;
    sram_write_en = 1'b1;
    sram_write_data = 32'h13572468;
    tick();
    sram_write_en = 1'b0;
    tick();
    expectEq("mid_cyc_before", wb.cyc, 1);
    rstn = 1'b0;
    tick();
    expectEq("mid_rst_cyc", wb.cyc, 0);
    expectEq("mid_rst_stb", wb.stb, 0);
    expectEq("mid_rst_we", wb.we, 0);
    expectEq("mid_rst_done", done, 0);
    expectEq("mid_rst_busy", busy, 0);
    expectEq("mid_rst_err", err, 0);
    expectEq("mid_rst_rdata", sram_read_data, 0);
    rstn = 1'b1;
    holdBad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || wb.cyc !== 1'b0) holdBad++;
    end
    expectEq("mid_rst_no_done", holdBad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_sram_line_en_master_bridge.md
WB_SRAM_LINE_EN_MASTER_BRIDGE -- requirements
Module: wb_sram_line_en_master_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 10, meaning Wishbone byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width (32 or 64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning watchdog limit in clk cycles (1..255).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sram_addr  input  ADDRESS_WIDTH-$clog2(DATA_WIDTH/8)  word address of request.
REQ-007 SHALL have port sram_read_en  input  1  read request strobe.
REQ-008 SHALL have port sram_write_en  input  1  write request strobe.
REQ-009 SHALL have port sram_write_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port sram_read_data  output  DATA_WIDTH  registered read result.
REQ-011 SHALL have port busy  output  1  high while a request is in flight; new strobes ignored.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  error status, valid while done=1.
REQ-014 SHALL have port wb_m  wb_if.master  -  Wishbone master (ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, ACK, ERR).

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DONE.
REQ-016 SHALL, in IDLE with sram_read_en or sram_write_en high, capture addr/data/direction and enter ACTIVE next edge.
REQ-017 SHALL treat sram_read_en and sram_write_en both high as a write; read ignored.
REQ-018 SHALL drive CYC=STB=1 from registers throughout ACTIVE only; CYC=STB=0 in IDLE and DONE.
REQ-019 SHALL drive ADR = {captured addr, $clog2(DATA_WIDTH/8) zero bits}, WE = captured direction, SEL all ones, DAT_W = captured data, all held stable in ACTIVE.
REQ-020 SHALL sample ACK/ERR only in ACTIVE; ACK or ERR in ACTIVE -> DONE next edge, CYC/STB low in the same edge.
REQ-021 SHALL load sram_read_data from DAT_R on ACK of a read; writes, ERR and timeout leave it unchanged.
REQ-022 SHALL give ERR priority over ACK when both high: err=1, read data not loaded.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE; err registered, held until next done.
REQ-024 SHALL have minimum latency: strobe at cycle 0, CYC at 1, ACK at 1, done at 2; strobe accepted again at cycle 3.
REQ-025 SHALL hold busy=1 in ACTIVE and DONE, 0 in IDLE; strobes while busy dropped, no queueing.

Reset
REQ-026 SHALL, on rstn=0 at a rising edge, enter IDLE with CYC=STB=WE=0, busy=0, done=0, err=0, sram_read_data=0, timeout counter=0.
REQ-027 SHALL, on reset mid-ACTIVE, deassert CYC/STB at that edge and emit no done.

Configuration
REQ-028 SHALL, with macro WB_SRAM_MASTER_TIMEOUT_EN defined, count cycles in ACTIVE; counter reaching TIMEOUT_CYCLES without ACK/ERR forces DONE with err=1, CYC dropped.
REQ-029 SHALL, without WB_SRAM_MASTER_TIMEOUT_EN, contain no counter and remain in ACTIVE indefinitely until ACK or ERR.

Verification
REQ-030 Write: sram_addr=0x05, data=0xDEADBEEF, ACK 2 cycles after CYC -> ADR=0x014, WE=1, DAT_W=0xDEADBEEF, one done pulse, err=0.
REQ-031 Read: sram_addr=0x0A, slave returns 0x12345678 with ACK -> ADR=0x028, WE=0, sram_read_data=0x12345678 at done, err=0.
REQ-032 Read with ERR=1 and ACK=1 same cycle -> done with err=1, sram_read_data keeps prior value.
REQ-033 Strobe while busy plus read_en&write_en together in IDLE -> busy strobe dropped (one Wishbone cycle only); simultaneous pair issues WE=1.
REQ-034 Macro defined, TIMEOUT_CYCLES=4, slave never acks -> CYC drops after 4 ACTIVE cycles, done=1, err=1; macro undefined -> CYC held 100+ cycles.
REQ-035 rstn=0 two cycles into ACTIVE -> CYC=0 next edge, no done, all outputs at reset values.
